// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: segment bit positions, hex glyph table and
// decoder FSM states. The glyph table is the same one the display encoder uses.
package seg7_pkg;

   localparam int A_BIT = 6;
   localparam int B_BIT = 5;
   localparam int C_BIT = 4;
   localparam int D_BIT = 3;
   localparam int E_BIT = 2;
   localparam int F_BIT = 1;
   localparam int G_BIT = 0;

   localparam logic [6:0] BLANK = 7'b0000000;

   // abcdefg glyphs indexed by nibble value
   localparam logic [6:0] HEX_SEG [16] = '{
      7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
      7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
      7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
      7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
   };

   typedef enum logic [1:0] {SETTLE, HOLD, WAIT} state_t;

endpackage

// File: rtl/seg7_pattern_lookup.sv
// Combinational reverse lookup of a segment pattern into a hex nibble.
// Patterns outside the glyph table flag o_err with o_nibble forced to 0.
module seg7_pattern_lookup
   import seg7_pkg::*;
(
   input  logic [6:0] i_seg,
   output logic       o_err,
   output logic [3:0] o_nibble
);

   always_comb begin
      o_err    = 1'b1;
      o_nibble = 4'd0;
      for (int i = 0; i < 16; i++) begin
         if (i_seg == HEX_SEG[i]) begin
            o_err    = 1'b0;
            o_nibble = 4'(i);
         end
      end
   end

endmodule

// File: rtl/seg7_decoder.sv
// Recovers hex digits from a multiplexed 7-segment bus: synchronize, debounce,
// decode once per stable pattern, and hand records out over valid/ready.
module seg7_decoder
   import seg7_pkg::*;
#(
   parameter int NUM_DIGITS    = 4,
   parameter int STABLE_CYCLES = 4,
   parameter int ERR_CNT_W     = 8,
   localparam int DIG_W        = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [6:0]            seg_in,
   input  logic [NUM_DIGITS-1:0] dig_sel,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [3:0]            out_nibble,
   output logic [DIG_W-1:0]      out_digit,
   output logic                  out_err,
   output logic [ERR_CNT_W-1:0]  err_cnt
);

   localparam int IN_W  = NUM_DIGITS + 7;
   localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STABLE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_TRIG = CNT_W'(STABLE_CYCLES - 1);

   logic [IN_W-1:0]       r_s1, r_s2, r_cand;
   logic [CNT_W-1:0]      r_cnt;
   state_t                r_state, w_state_nxt;

   logic                  r_out_valid, r_out_err;
   logic [3:0]            r_out_nibble;
   logic [DIG_W-1:0]      r_out_digit;
   logic                  r_pend_err;
   logic [3:0]            r_pend_nibble;
   logic [DIG_W-1:0]      r_pend_digit;
   logic [ERR_CNT_W-1:0]  r_err_cnt;

   logic [NUM_DIGITS-1:0] w_cand_sel;
   logic [6:0]            w_cand_seg;
   logic                  w_onehot, w_drop, w_stable_edge, w_slot_free;
   logic                  w_lk_err;
   logic [3:0]            w_lk_nibble;
   logic [DIG_W-1:0]      w_idx;
   logic                  w_load_new, w_load_pend, w_move_pend, w_rec_err;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s1   <= '0;
         r_s2   <= '0;
         r_cand <= '0;
         r_cnt  <= '0;
      end else begin
         r_s1 <= {dig_sel, seg_in};
         r_s2 <= r_s1;
         if (r_s2 != r_cand) begin
            r_cand <= r_s2;
            r_cnt  <= CNT_W'(1);
         end else if (r_cnt != CNT_MAX) begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
      end
   end

   assign w_cand_sel    = r_cand[IN_W-1:7];
   assign w_cand_seg    = r_cand[6:0];
   assign w_onehot      = (w_cand_sel != '0) &&
                          ((w_cand_sel & (w_cand_sel - NUM_DIGITS'(1))) == '0);
   assign w_drop        = !w_onehot || (w_cand_seg == BLANK);
   // Fires on the edge where the debounce count reaches STABLE_CYCLES
   assign w_stable_edge = (r_s2 == r_cand) && (r_cnt == CNT_TRIG);
   assign w_slot_free   = !r_out_valid || out_ready;

   seg7_pattern_lookup u_lookup (
      .i_seg    (w_cand_seg),
      .o_err    (w_lk_err),
      .o_nibble (w_lk_nibble)
   );

   always_comb begin
      w_idx = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (w_cand_sel[i]) w_idx = DIG_W'(i);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= SETTLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_load_new  = 1'b0;
      w_load_pend = 1'b0;
      w_move_pend = 1'b0;
      case (r_state)
         SETTLE: begin
            if (w_stable_edge) begin
               w_state_nxt = HOLD;
               if (!w_drop) begin
                  if (w_slot_free) begin
                     w_load_new = 1'b1;
                  end else begin
                     w_load_pend = 1'b1;
                     w_state_nxt = WAIT;
                  end
               end
            end
         end
         HOLD: begin
            if (r_s2 != r_cand) w_state_nxt = SETTLE;
         end
         WAIT: begin
            if (w_slot_free) begin
               w_move_pend = 1'b1;
               w_state_nxt = HOLD;
            end
         end
         default: w_state_nxt = SETTLE;
      endcase
   end

   assign w_rec_err = w_load_new ? w_lk_err : (w_move_pend && r_pend_err);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_out_valid   <= 1'b0;
         r_out_err     <= 1'b0;
         r_out_nibble  <= '0;
         r_out_digit   <= '0;
         r_pend_err    <= 1'b0;
         r_pend_nibble <= '0;
         r_pend_digit  <= '0;
         r_err_cnt     <= '0;
      end else begin
         if (w_load_new) begin
            r_out_valid  <= 1'b1;
            r_out_err    <= w_lk_err;
            r_out_nibble <= w_lk_nibble;
            r_out_digit  <= w_idx;
         end else if (w_move_pend) begin
            r_out_valid  <= 1'b1;
            r_out_err    <= r_pend_err;
            r_out_nibble <= r_pend_nibble;
            r_out_digit  <= r_pend_digit;
         end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
         end
         if (w_load_pend) begin
            r_pend_err    <= w_lk_err;
            r_pend_nibble <= w_lk_nibble;
            r_pend_digit  <= w_idx;
         end
         if ((w_load_new || w_move_pend) && w_rec_err && !(&r_err_cnt))
            r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
      end
   end

   assign out_valid  = r_out_valid;
   assign out_err    = r_out_err;
   assign out_nibble = r_out_nibble;
   assign out_digit  = r_out_digit;
   assign err_cnt    = r_err_cnt;

endmodule

// File: tb/tb_seg7_decoder.sv
// Directed bench for seg7_decoder: reset, single digit, table sweep,
// glitch/invalid inputs, backpressure and reset while a record is pending.
module tb_seg7_decoder;

   logic       clk = 1'b0;
   logic       rst;
   logic [6:0] seg_in;
   logic [3:0] dig_sel;
   logic       out_ready;
   logic       out_valid, out_err;
   logic [3:0] out_nibble;
   logic [1:0] out_digit;
   logic [7:0] err_cnt;

   seg7_decoder #(.NUM_DIGITS(4), .STABLE_CYCLES(4), .ERR_CNT_W(8)) dut (
      .clk(clk), .rst(rst), .seg_in(seg_in), .dig_sel(dig_sel),
      .out_valid(out_valid), .out_ready(out_ready), .out_nibble(out_nibble),
      .out_digit(out_digit), .out_err(out_err), .err_cnt(err_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] nib;
      logic [1:0] dig;
      logic       err;
      int         at_edge;
   } rec_t;

   rec_t recs[$];
   int   edge_n;
   int   n_checks = 0;
   int   n_fail   = 0;

   logic [6:0] glyph [16] = '{
      7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
      7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
   };

   // Records are logged at the edge that accepts them
   task automatic tick();
      if (out_valid && out_ready) begin
         rec_t r;
         r.nib = out_nibble; r.dig = out_digit; r.err = out_err; r.at_edge = edge_n + 1;
         recs.push_back(r);
      end
      @(posedge clk); #1;
      edge_n++;
   endtask

   task automatic run(input int n);
      repeat (n) tick();
   endtask

   task automatic apply(input logic [3:0] d, input logic [6:0] s, input int n);
      dig_sel = d;
      seg_in  = s;
      run(n);
   endtask

   task automatic test_reset();
      rst = 1'b1; seg_in = '0; dig_sel = '0; out_ready = 1'b0;
      #12;
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b exp 0", out_valid); end
      n_checks++; if (out_nibble !== 4'd0) begin n_fail++; $display("FAIL rst_nibble: got %h exp 0", out_nibble); end
      n_checks++; if (out_digit !== 2'd0) begin n_fail++; $display("FAIL rst_digit: got %0d exp 0", out_digit); end
      n_checks++; if (out_err !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b exp 0", out_err); end
      n_checks++; if (err_cnt !== 8'd0) begin n_fail++; $display("FAIL rst_errcnt: got %0d exp 0", err_cnt); end
      @(posedge clk); #1;
      rst = 1'b0; out_ready = 1'b1;
      recs.delete(); edge_n = 0;
      run(20);
      n_checks++; if (recs.size() != 0) begin n_fail++; $display("FAIL rst_quiet: got %0d records exp 0", recs.size()); end
   endtask

   task automatic test_digit3();
      recs.delete(); edge_n = 0;
      apply(4'b0100, 7'b1111001, 20);
      n_checks++; if (recs.size() != 1) begin n_fail++; $display("FAIL d3_count: got %0d exp 1", recs.size()); end
      if (recs.size() == 1) begin
         n_checks++; if (recs[0].at_edge != 7) begin n_fail++; $display("FAIL d3_latency: accepted at edge %0d exp 7", recs[0].at_edge); end
         n_checks++; if (recs[0].nib !== 4'h3) begin n_fail++; $display("FAIL d3_nibble: got %h exp 3", recs[0].nib); end
         n_checks++; if (recs[0].dig !== 2'd2) begin n_fail++; $display("FAIL d3_digit: got %0d exp 2", recs[0].dig); end
         n_checks++; if (recs[0].err !== 1'b0) begin n_fail++; $display("FAIL d3_err: got %b exp 0", recs[0].err); end
      end
   endtask

   task automatic test_sweep();
      recs.delete();
      for (int v = 0; v < 16; v++) apply(4'b0001, glyph[v], 10);
      n_checks++; if (recs.size() != 16) begin n_fail++; $display("FAIL sweep_count: got %0d exp 16", recs.size()); end
      for (int i = 0; i < recs.size(); i++) begin
         n_checks++;
         if (recs[i].nib !== 4'(i) || recs[i].dig !== 2'd0 || recs[i].err !== 1'b0) begin
            n_fail++;
            $display("FAIL sweep_rec%0d: got nib=%h dig=%0d err=%b exp nib=%h dig=0 err=0",
                     i, recs[i].nib, recs[i].dig, recs[i].err, 4'(i));
         end
      end
   endtask

   task automatic test_glitch_invalid();
      recs.delete();
      apply(4'b0001, 7'b0000000, 10);
      apply(4'b0001, 7'b0110000, 3);
      apply(4'b0001, 7'b0000000, 10);
      n_checks++; if (recs.size() != 0) begin n_fail++; $display("FAIL glitch: got %0d records exp 0", recs.size()); end
      recs.delete();
      apply(4'b0001, 7'b1010101, 10);
      n_checks++; if (recs.size() != 1) begin n_fail++; $display("FAIL inv_count: got %0d exp 1", recs.size()); end
      if (recs.size() == 1) begin
         n_checks++; if (recs[0].err !== 1'b1) begin n_fail++; $display("FAIL inv_err: got %b exp 1", recs[0].err); end
         n_checks++; if (recs[0].nib !== 4'h0) begin n_fail++; $display("FAIL inv_nibble: got %h exp 0", recs[0].nib); end
      end
      n_checks++; if (err_cnt !== 8'd1) begin n_fail++; $display("FAIL inv_errcnt: got %0d exp 1", err_cnt); end
      apply(4'b0001, 7'b0000000, 10);
      recs.delete();
      apply(4'b0011, 7'b1111110, 10);
      n_checks++; if (recs.size() != 0) begin n_fail++; $display("FAIL multihot: got %0d records exp 0", recs.size()); end
   endtask

   task automatic test_back_to_back();
      out_ready = 1'b0;
      recs.delete();
      apply(4'b0001, 7'b1011011, 10);
      apply(4'b0010, 7'b1110111, 10);
      n_checks++;
      if (out_valid !== 1'b1 || out_nibble !== 4'h5 || out_digit !== 2'd0) begin
         n_fail++;
         $display("FAIL bp_hold: got v=%b nib=%h dig=%0d exp v=1 nib=5 dig=0", out_valid, out_nibble, out_digit);
      end
      apply(4'b0100, 7'b1110000, 10);
      n_checks++; if (out_nibble !== 4'h5) begin n_fail++; $display("FAIL bp_hold2: got %h exp 5", out_nibble); end
      out_ready = 1'b1;
      run(20);
      n_checks++; if (recs.size() != 2) begin n_fail++; $display("FAIL bp_count: got %0d exp 2", recs.size()); end
      if (recs.size() == 2) begin
         n_checks++;
         if (recs[0].nib !== 4'h5 || recs[0].dig !== 2'd0) begin
            n_fail++; $display("FAIL bp_first: got nib=%h dig=%0d exp nib=5 dig=0", recs[0].nib, recs[0].dig);
         end
         n_checks++;
         if (recs[1].nib !== 4'hA || recs[1].dig !== 2'd1 || recs[1].err !== 1'b0) begin
            n_fail++; $display("FAIL bp_second: got nib=%h dig=%0d err=%b exp nib=a dig=1 err=0",
                               recs[1].nib, recs[1].dig, recs[1].err);
         end
         n_checks++;
         if (recs[1].at_edge != recs[0].at_edge + 1) begin
            n_fail++; $display("FAIL bp_consec: accept edges %0d,%0d exp consecutive", recs[0].at_edge, recs[1].at_edge);
         end
      end
      n_checks++; if (err_cnt !== 8'd1) begin n_fail++; $display("FAIL bp_errcnt: got %0d exp 1", err_cnt); end
   endtask

   task automatic test_reset_wait();
      out_ready = 1'b0;
      apply(4'b0001, 7'b1101101, 10);
      apply(4'b1000, 7'b0110011, 10);
      n_checks++;
      if (out_valid !== 1'b1 || out_nibble !== 4'h2) begin
         n_fail++; $display("FAIL rw_pre: got v=%b nib=%h exp v=1 nib=2", out_valid, out_nibble);
      end
      #2 rst = 1'b1;
      #1;
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rw_async_valid: got %b exp 0", out_valid); end
      n_checks++; if (err_cnt !== 8'd0) begin n_fail++; $display("FAIL rw_async_errcnt: got %0d exp 0", err_cnt); end
      n_checks++; if (out_nibble !== 4'd0) begin n_fail++; $display("FAIL rw_async_nibble: got %h exp 0", out_nibble); end
      seg_in = '0; dig_sel = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      out_ready = 1'b1;
      recs.delete();
      run(20);
      n_checks++; if (recs.size() != 0) begin n_fail++; $display("FAIL rw_stale: got %0d records exp 0", recs.size()); end
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rw_valid: got %b exp 0", out_valid); end
   endtask

   initial begin
      edge_n = 0;
      test_reset();
      test_digit3();
      test_sweep();
      test_glitch_invalid();
      test_back_to_back();
      test_reset_wait();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/seg7_decoder.md
Name: seg7_decoder

Overview:
- Inverse of the team's hex-to-7-segment display encoder: observes a multiplexed 7-segment display bus (one-hot digit select plus segment lines) and recovers the hex nibble shown on each digit.
- Debounces each pattern for a programmable number of cycles, then emits one decoded record per stable pattern through a valid/ready output port.
- Used as a loop-back checker behind the display driver and as a front end for scraping external displays.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digit positions (>=1).
- STABLE_CYCLES, 4, consecutive identical synchronized samples required before emission (>=2).
- ERR_CNT_W, 8, width of the saturating invalid-pattern counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- seg_in  in  7  segment lines, active-high; bit6=a, bit5=b, bit4=c, bit3=d, bit2=e, bit1=f, bit0=g.
- dig_sel  in  NUM_DIGITS  one-hot active digit, active-high.
- out_valid  out  1  decoded record available.
- out_ready  in  1  consumer accepts the record when high with out_valid.
- out_nibble  out  4  decoded value; bit3=S3 (MSB) .. bit0=S0 (LSB).
- out_digit  out  max(1,clog2(NUM_DIGITS))  index of the set dig_sel bit.
- out_err  out  1  pattern not in the hex table; out_nibble=0 in that case.
- err_cnt  out  ERR_CNT_W  saturating count of emitted error records.

Behaviour:
- Reset (async assert, sync release): all outputs 0; synchronizer, candidate and pending registers 0; FSM in SETTLE with cnt=0.
- Input path: {dig_sel, seg_in} passes through a 2-flop synchronizer (s1, s2). The candidate register cand holds the last s2 value.
- Candidate update on each edge:
  - s2 != cand: cand<=s2 and cnt<=1.
  - Otherwise cnt increments, saturating at STABLE_CYCLES.
- Decode table (abcdefg -> nibble): 1111110=0, 0110000=1, 1101101=2, 1111001=3, 0110011=4, 1011011=5, 1011111=6, 1110000=7, 1111111=8, 1111011=9, 1110111=A, 0011111=b, 1001110=C, 0111101=d, 1001111=E, 1000111=F. Any other non-zero pattern is an error record.
- FSM states:
  - SETTLE: on the edge where cnt becomes STABLE_CYCLES, select the next state:
    - dig_sel is not one-hot (zero or multi-hot), or the segment pattern is blank (0000000): no record; go to HOLD.
    - Output slot empty, or draining this cycle (out_valid&&out_ready): load the record into the output register; go to HOLD.
    - Slot full and not draining: load the record into the pending register; go to WAIT.
  - WAIT: input changes are ignored (cand/cnt keep tracking). When the slot frees, move pending to output on that edge; go to HOLD.
  - HOLD: stays while s2==cand. On any change, return to SETTLE with cnt=1. An unchanged pattern never emits twice.
- Latency: a pattern applied before edge 1 and held produces out_valid high after edge STABLE_CYCLES+2 (edge 6 at default), provided the slot is free.
- Output register:
  - Holds its value while out_valid&&!out_ready.
  - Clears out_valid on acceptance unless reloaded on the same edge.
  - Back-to-back accept and reload is allowed.
- err_cnt increments when an error record is loaded into the output register, and saturates at all-ones.
- Pattern shorter than STABLE_CYCLES: silently discarded.
- Reset asserted mid-operation: immediate return to the reset state; any pending or output record is lost.

Decomposition:
- Shared package seg7_pkg:
  - Segment bit-index constants A_BIT..G_BIT.
  - 16-entry hex-to-segment constant table, shared with the encoder.
  - BLANK pattern constant.
  - FSM state typedef {SETTLE, HOLD, WAIT}.
- One sub-module, seg7_pattern_lookup: combinational 7-bit pattern -> {err, nibble}, driven from the package table.

Test Plan:
- Reset check: rst high then low, inputs static -> all outputs 0, no out_valid for 20 cycles.
- Digit "3" on digit 2: dig_sel=0100, seg_in=1111001 held, out_ready=1 -> out_valid high after edge 6 for exactly one cycle, out_nibble=3, out_digit=2, out_err=0; no repeat while held.
- Full sweep: all 16 table patterns on digit 0, each held 10 cycles, out_ready=1 -> 16 records 0..F in order, out_err=0 throughout.
- Glitch and invalid inputs: a 3-cycle pulse of 0110000 -> no record; a held 1010101 -> record with out_err=1, out_nibble=0, err_cnt=1; dig_sel=0011 -> no record.
- Backpressure: out_ready=0, two patterns 5 (digit 0) then A (digit 1) each held 10 cycles -> 5 stays valid, A pending; raise out_ready -> 5 then A on consecutive accept cycles; a third pattern during WAIT is ignored.
- Reset mid-WAIT: assert rst with a record pending -> out_valid=0 immediately (async); after release no stale record appears.
